uart_rx_sipo: RTL and testbench

UART receive stage: the serial-in/parallel-out counterpart that consumes the line driven by the transmit PISO (idle-high, start bit 0, WIDTH data bits LSB first, one stop bit 1).
- Synchronises the asynchronous line and detects the start edge.
- Samples each bit at its centre using an internal bit-period counter.
- Presents the received word with a valid/ack handshake, plus framing-error and overrun status.

---
 rtl/uart_rx_sipo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_sipo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sipo.sv
// UART receiver: two-flop line synchroniser, centre-sampling frame FSM and a
// valid/ack output register with framing-error pulse and sticky overrun.
module uart_rx_sipo #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy,
    output logic [3:0]       bit_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             rx_meta;
    logic             rx_s;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;

    // Reset to the idle (high) line level so no false start is seen on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        shifted            = shreg >> 1;
        shifted[WIDTH-1]   = rx_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
            bit_count  <= 4'd0;
        end else begin
            frame_err <= 1'b0;
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        bit_count <= 4'd0;
                        busy      <= 1'b1;
                    end
                end

                // A start bit that is high again at its centre was only a glitch.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state     <= DATA;
                            bit_count <= 4'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt       <= '0;
                        shreg     <= shifted;
                        bit_count <= bit_count + 4'd1;
                        if (bit_count == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Returning to IDLE at mid-stop-bit leaves room for an immediate next start.
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: frames are driven serially, expected words
// are queued at send time and matched by a monitor when the DUT completes.
module tb_uart_rx_sipo;

    localparam int WIDTH   = 8;
    localparam int CPB     = 16;
    localparam int LATENCY = CPB / 2 + (WIDTH + 1) * CPB + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             rx = 1'b1;
    logic             data_ack = 1'b0;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;
    logic [3:0]       bit_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_edge = 0;
    int valid_edge = 0;
    int fe_count = 0;
    int done_count = 0;
    bit auto_ack = 1'b0;
    bit ack_now = 1'b0;
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic [WIDTH-1:0] exp_q[$];

    uart_rx_sipo #(
        .WIDTH(WIDTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data_ack(data_ack),
        .data(data),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a falling clock edge; fall_edge is the first
    // rising edge that captures the start bit.
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic stop_bit);
        rx = 1'b0;
        fall_edge = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            rx = word[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // A completion is a rising data_valid, or a new word replacing an unacked one.
    always @(negedge clk) begin
        if (data_ack) data_ack = 1'b0;
        if (!reset) begin
            prev_valid = 1'b0;
            prev_data  = '0;
        end else begin
            if (frame_err) fe_count++;
            if (data_valid && (!prev_valid || data !== prev_data)) begin
                done_count++;
                valid_edge = cyc;
                checkOutput("word_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    checkOutput("word", 32'(data), 32'(exp_q.pop_front()));
                end
                if (auto_ack) data_ack = 1'b1;
            end
            if (ack_now && data_valid && !data_ack) begin
                data_ack = 1'b1;
                ack_now  = 1'b0;
            end
            prev_valid = data_valid;
            prev_data  = data;
        end
    end

    initial begin
        int fe0;
        int d0;
        logic [WIDTH-1:0] partial;

        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_data", 32'(data), 32'(0));
        checkOutput("rst_valid", 32'(data_valid), 32'(0));
        checkOutput("rst_frame_err", 32'(frame_err), 32'(0));
        checkOutput("rst_overrun", 32'(overrun), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_bit_count", 32'(bit_count), 32'(0));
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame with latency measurement
        auto_ack = 1'b1;
        fe0 = fe_count;
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_latency", 32'(valid_edge - fall_edge), 32'(LATENCY));
        checkOutput("a5_drained", 32'(exp_q.size()), 32'(0));
        checkOutput("a5_busy", 32'(busy), 32'(0));
        checkOutput("a5_frame_err", 32'(fe_count - fe0), 32'(0));
        checkOutput("a5_overrun", 32'(overrun), 32'(0));
        checkOutput("a5_bit_count", 32'(bit_count), 32'(WIDTH));
        checkOutput("a5_acked", 32'(data_valid), 32'(0));

        // Back-to-back frames, acked
        d0 = done_count;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("b2b_count", 32'(done_count - d0), 32'(2));
        checkOutput("b2b_drained", 32'(exp_q.size()), 32'(0));
        checkOutput("b2b_data", 32'(data), 32'(8'hFF));
        checkOutput("b2b_overrun", 32'(overrun), 32'(0));

        // Short glitch while idle
        d0  = done_count;
        fe0 = fe_count;
        rx  = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("glitch_busy_seen", 32'(busy), 32'(1));
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_busy", 32'(busy), 32'(0));
        checkOutput("glitch_no_word", 32'(done_count - d0), 32'(0));
        checkOutput("glitch_no_ferr", 32'(fe_count - fe0), 32'(0));
        checkOutput("glitch_valid", 32'(data_valid), 32'(0));

        // Overrun: two frames without ack
        auto_ack = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        applyStimulus(8'h11, 1'b1);
        checkOutput("ovr_first_valid", 32'(data_valid), 32'(1));
        checkOutput("ovr_first_flag", 32'(overrun), 32'(0));
        applyStimulus(8'h22, 1'b1);
        checkOutput("ovr_data", 32'(data), 32'(8'h22));
        checkOutput("ovr_valid", 32'(data_valid), 32'(1));
        checkOutput("ovr_flag", 32'(overrun), 32'(1));
        checkOutput("ovr_drained", 32'(exp_q.size()), 32'(0));
        ack_now = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("ovr_ack_valid", 32'(data_valid), 32'(0));
        checkOutput("ovr_sticky", 32'(overrun), 32'(1));

        // Reset in the middle of data bit 4
        partial = 8'h5A;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rx = partial[4];
        repeat (CPB / 2) @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_data", 32'(data), 32'(0));
        checkOutput("mid_rst_valid", 32'(data_valid), 32'(0));
        checkOutput("mid_rst_overrun", 32'(overrun), 32'(0));
        checkOutput("mid_rst_busy", 32'(busy), 32'(0));
        checkOutput("mid_rst_bit_count", 32'(bit_count), 32'(0));
        checkOutput("mid_rst_frame_err", 32'(frame_err), 32'(0));
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        auto_ack = 1'b1;
        exp_q.push_back(8'hC3);
        applyStimulus(8'hC3, 1'b1);
        checkOutput("c3_drained", 32'(exp_q.size()), 32'(0));
        checkOutput("c3_data", 32'(data), 32'(8'hC3));

        // Framing error followed by a long break
        fe0 = fe_count;
        d0  = done_count;
        applyStimulus(8'h55, 1'b0);
        repeat (39 * CPB) @(negedge clk);
        checkOutput("brk_one_ferr", 32'(fe_count - fe0), 32'(1));
        checkOutput("brk_busy", 32'(busy), 32'(1));
        checkOutput("brk_data", 32'(data), 32'(8'hC3));
        checkOutput("brk_valid", 32'(data_valid), 32'(0));
        checkOutput("brk_no_word", 32'(done_count - d0), 32'(0));
        rx = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("brk_exit_busy", 32'(busy), 32'(0));
        checkOutput("brk_exit_ferr", 32'(fe_count - fe0), 32'(1));
        exp_q.push_back(8'h81);
        applyStimulus(8'h81, 1'b1);
        checkOutput("x81_drained", 32'(exp_q.size()), 32'(0));
        checkOutput("x81_data", 32'(data), 32'(8'h81));
        checkOutput("x81_overrun", 32'(overrun), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
